// File: rtl/md_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU function codes
// for the M extension, the unit's state type and the unknown-function marker.
package md_unit_pkg;

  localparam logic [4:0] ALU_MUL    = 5'h0a;
  localparam logic [4:0] ALU_MULH   = 5'h0b;
  localparam logic [4:0] ALU_MULHSU = 5'h0c;
  localparam logic [4:0] ALU_MULHU  = 5'h0d;
  localparam logic [4:0] ALU_DIV    = 5'h0e;
  localparam logic [4:0] ALU_DIVU   = 5'h0f;
  localparam logic [4:0] ALU_REM    = 5'h10;
  localparam logic [4:0] ALU_REMU   = 5'h11;

  // Result returned for a function code the unit does not implement
  localparam logic [31:0] MD_BAAD_WORD = 32'hbaadbeef;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/md_divider.sv
// Unsigned XLEN-bit radix-2 restoring divider. A start pulse loads the
// operands; one quotient bit is produced per cycle, indexed by a counter
// running XLEN-1 down to 0. o_done is high during the final iteration, so
// quotient and remainder are valid from the following cycle on.
module md_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            r_run;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;

  logic [XLEN:0]   w_shift;
  logic            w_fits;
  logic [XLEN-1:0] w_diff;

  // Partial remainder with the next dividend bit appended; the subtraction
  // is only kept when the divisor fits, and then the result is below 2^XLEN.
  assign w_shift = {r_rem, r_dvd[r_cnt]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[XLEN-1:0] - r_dvs;

  // Load on start, then one restoring step per cycle until the counter hits 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_quo <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= CW'(XLEN - 1);
      r_dvd <= i_dividend;
      r_dvs <= i_divisor;
      r_rem <= '0;
      r_quo <= '0;
    end else if (r_run) begin
      r_rem        <= w_fits ? w_diff : w_shift[XLEN-1:0];
      r_quo[r_cnt] <= w_fits;
      r_cnt        <= r_cnt - CW'(1);
      if (r_cnt == '0) r_run <= 1'b0;
    end
  end

  assign o_done      = r_run && (r_cnt == '0);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle RV32M multiply/divide unit. One operation is accepted through a
// valid/ready handshake; the result is held until the consumer takes it.
// Multiply completes in one registered cycle; divide runs the restoring core
// and fixes signs afterwards. Divide-by-zero, signed overflow and unknown
// function codes complete straight away.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       func,
  input  logic [XLEN-1:0]  opa,
  input  logic [XLEN-1:0]  opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [XLEN-1:0] LP_BAAD = XLEN'(MD_BAAD_WORD);
  localparam logic [XLEN-1:0] LP_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        r_state, w_next;
  logic [4:0]       r_func;
  logic [XLEN-1:0]  r_opa, r_opb;
  logic             r_q_neg, r_r_neg;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag;

  logic            w_accept, w_is_mul, w_is_div, w_signed_div;
  logic            w_div_skip, w_div_start, w_div_done;
  logic [XLEN-1:0] w_fast_res, w_abs_a, w_abs_b, w_quo, w_rem, w_div_res;
  logic [XLEN:0]   w_a_ext, w_b_ext;
  logic [2*XLEN-1:0] w_a_wide, w_b_wide, w_prod;
  logic [XLEN-1:0] w_mul_res;

  assign in_ready  = (r_state == MD_IDLE);
  assign busy      = (r_state != MD_IDLE);
  assign out_valid = (r_state == MD_DONE);
  assign result    = r_result;
  assign out_tag   = r_tag;

  assign w_accept     = in_valid && in_ready && !flush;
  assign w_is_mul     = (func >= ALU_MUL) && (func <= ALU_MULHU);
  assign w_is_div     = (func >= ALU_DIV) && (func <= ALU_REMU);
  assign w_signed_div = (func == ALU_DIV) || (func == ALU_REM);
  assign w_div_skip   = w_is_div && ((opb == '0) ||
                        (w_signed_div && (opa == LP_MIN) && (opb == '1)));
  assign w_div_start  = w_accept && w_is_div && !w_div_skip;

  assign w_abs_a = (w_signed_div && opa[XLEN-1]) ? -opa : opa;
  assign w_abs_b = (w_signed_div && opb[XLEN-1]) ? -opb : opb;

  // Result for operations that complete on the accept edge
  always_comb begin
    w_fast_res = LP_BAAD;
    if (w_is_div) begin
      if (opb == '0)
        w_fast_res = ((func == ALU_DIV) || (func == ALU_DIVU)) ? '1 : opa;
      else
        w_fast_res = (func == ALU_DIV) ? opa : '0;
    end
  end

  // The top two bits of the (2*XLEN+2)-bit product never reach the result,
  // so the sign-extended operands are multiplied modulo 2^(2*XLEN).
  assign w_a_ext  = {((r_func == ALU_MULH) || (r_func == ALU_MULHSU)) && r_opa[XLEN-1], r_opa};
  assign w_b_ext  = {(r_func == ALU_MULH) && r_opb[XLEN-1], r_opb};
  assign w_a_wide = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
  assign w_b_wide = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
  assign w_prod   = w_a_wide * w_b_wide;
  assign w_mul_res = (r_func == ALU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_div_res = ((r_func == ALU_DIV) || (r_func == ALU_DIVU))
                     ? (r_q_neg ? -w_quo : w_quo)
                     : (r_r_neg ? -w_rem : w_rem);

  md_divider #(.XLEN(XLEN)) u_div (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_start     (w_div_start),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; flush returns to IDLE from anywhere
  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) begin
        if (w_is_mul)                     w_next = MD_MUL;
        else if (w_is_div && !w_div_skip) w_next = MD_DIV;
        else                              w_next = MD_DONE;
      end
      MD_MUL:  w_next = MD_DONE;
      MD_DIV:  if (w_div_done) w_next = MD_FIX;
      MD_FIX:  w_next = MD_DONE;
      MD_DONE: if (out_ready) w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
    if (flush) w_next = MD_IDLE;
  end

  // Operand latch on accept and result capture on completion
  always_ff @(posedge clock) begin
    if (reset) begin
      r_func   <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= '0;
      r_tag    <= '0;
    end else begin
      if (w_accept) begin
        r_func   <= func;
        r_opa    <= opa;
        r_opb    <= opb;
        r_tag    <= in_tag;
        r_q_neg  <= w_signed_div && (opa[XLEN-1] ^ opb[XLEN-1]);
        r_r_neg  <= w_signed_div && opa[XLEN-1];
        r_result <= w_fast_res;
      end
      if (r_state == MD_MUL) r_result <= w_mul_res;
      if (r_state == MD_FIX) r_result <= w_div_res;
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised, multi-cycle multiply/divide execution unit for the RV32M path. Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in EX beside the single-cycle ALU. The pipeline issues one operation through a valid/ready handshake, then stalls dependants until the result handshake completes.
- Multiply is registered (one cycle). Divide is an iterative radix-2 restoring divider with RISC-V corner-case handling.

Parameters:
- XLEN, 32, operand/result width; even, at least 8.
- TAG_W, 5, width of the opaque tag carried with the operation (destination register).

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of the in-flight operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept an operation.
- func  in  5  ALU function code (`ALU_MUL..`ALU_REMU).
- opa  in  XLEN  rs1 operand.
- opb  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  result value.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; out_tag=0; busy=0. Reset overrides every other input in the same cycle.
- Accept: an operation is accepted on a cycle where in_valid && in_ready. opa, opb, func and in_tag are latched on that cycle. in_ready=1 only in IDLE.
- States and transitions:
  - IDLE: on accept, go to MUL, DIV or DONE.
  - MUL: 1 cycle, then DONE.
  - DIV: XLEN iterations, then FIX.
  - FIX: 1 cycle, then DONE.
  - DONE: hold until out_ready.
- Multiply:
  - Sign-extend opa and opb to XLEN+1 bits. Sign is used for MULH (a, b), MULHSU (a only), and for neither in MUL/MULHU. Form a 2*XLEN+2-bit product.
  - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
  - out_valid rises 2 cycles after the accept edge: accept at cycle t, MUL at t+1, DONE at t+2.
- Divide, normal case:
  - Signed ops take the magnitudes of the operands and record the quotient sign (sa^sb) and remainder sign (sa).
  - Each DIV cycle shifts one quotient bit into a counter-indexed register; the counter runs XLEN-1 down to 0.
  - FIX applies negation by sign. The remainder takes the sign of the dividend.
  - out_valid at t+XLEN+2.
- Divide by zero: detected at accept; skips to DONE; out_valid at t+1.
  - DIV/DIVU: result = all-ones.
  - REM/REMU: result = opa.
- Signed overflow (opa = -2^(XLEN-1), opb = -1, DIV/REM only): skips to DONE.
  - DIV: result = opa.
  - REM: result = 0.
- Unknown func: accepted; DONE at t+1; result = 32'hbaadbeef zero-extended, or truncated to its low XLEN bits if XLEN<32.
- DONE: result and out_tag are stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE next cycle (out_valid=0, in_ready=1). No same-cycle re-accept.
- flush: go to IDLE next cycle from any state and drop the result. If flush coincides with in_valid, nothing is accepted. flush has priority over out_ready.
- result and out_tag are registered; no combinational path from inputs to outputs except none. in_ready and busy are decoded from state.

Decomposition:
- Shared header sys_defs.vh: activate the existing `ALU_DIV, `ALU_DIVU, `ALU_REM and `ALU_REMU codes beside `ALU_MUL..`ALU_MULHU. Add md state encoding constants (MD_IDLE, MD_MUL, MD_DIV, MD_FIX, MD_DONE).
- Sub-module md_divider: unsigned XLEN-bit iterative restoring core with start, done, quotient and remainder.
- Sign handling, corner cases, multiply and the FSM stay in md_unit.

Test Plan:
- MULH, opa=-3 (0xFFFFFFFD), opb=5 -> result 0xFFFFFFFF at t+2. MULHU with the same operands -> 0x00000004. MUL -> 0xFFFFFFF1.
- DIV opa=-7, opb=2 -> 0xFFFFFFFD (-3) at t+34. REM with the same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at t+1. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- DONE back-pressure: out_ready=0 for 5 cycles -> out_valid stays 1, result and out_tag unchanged, in_ready=0. Raise out_ready -> in_ready=1 on the next cycle.
- flush at iteration 10 of a DIV -> IDLE on the next cycle, out_valid never asserted. A following MUL 6*7 -> 42 with its own tag.
- reset asserted mid-DIV and in DONE -> all outputs at reset values on the next cycle. XLEN=16 build: DIV -32768/-1 -> 0x8000.
